pow5_pipe_arbiter: RTL and testbench

Shares one fully pipelined, fixed-latency pow5 datapath (result = x^5) between N requesters.
- Round-robin arbitration issues at most one operand per cycle into the pipe.
- A tag shift register tracks which requester owns each in-flight slot.
- Each result returns to its owner with a one-cycle valid pulse.
- Sits between the lab_top input sources (switches/keys or generators) and the pow5 pipeline instance.

---
 rtl/pow5_pipe_arbiter.sv | 131 +++++++++++++
 tb/tb_pow5_pipe_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pow5_pipe_arbiter.sv
// Round-robin front end that shares one fixed-latency pow5 pipe among N requesters,
// tracking slot ownership with a tag shift register so each result returns to its owner.
module pow5_pipe_arbiter #(
    parameter int N       = 4,
    parameter int WIDTH   = 8,
    parameter int LATENCY = 4,
    parameter int RES_W   = 5 * WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [N-1:0]         req_vld,
    input  logic [N*WIDTH-1:0]   req_data,
    output logic [N-1:0]         req_rdy,
    output logic                 pipe_vld,
    output logic [WIDTH-1:0]     pipe_data,
    input  logic                 pipe_res_vld,
    input  logic [RES_W-1:0]     pipe_res,
    output logic [N-1:0]         res_vld,
    output logic [RES_W-1:0]     res_data,
    output logic                 err
);

    localparam int IDW = (N > 1) ? $clog2(N) : 1;

    logic [IDW-1:0]   ptr_q, ptr_d;
    logic             gnt_vld;
    logic [IDW-1:0]   gnt_id;
    logic [IDW-1:0]   scan_idx;
    logic [WIDTH-1:0] gnt_data;

    logic             pipe_vld_q;
    logic [WIDTH-1:0] pipe_data_q, pipe_data_d;
    logic [IDW-1:0]   pipe_id_q;

    logic [LATENCY-1:0] tag_vld_q;
    logic [IDW-1:0]     tag_id_q [LATENCY];
    logic               head_vld;
    logic [IDW-1:0]     head_id;

    logic [N-1:0]     res_vld_q, res_vld_d;
    logic [RES_W-1:0] res_data_q, res_data_d;
    logic             err_q, err_d;

    // Grant: first requester at or after the pointer, wrapping modulo N
    always_comb begin
        gnt_vld  = 1'b0;
        gnt_id   = '0;
        scan_idx = '0;
        req_rdy  = '0;
        gnt_data = '0;
        if (en && !rst) begin
            for (int k = 0; k < N; k++) begin
                scan_idx = IDW'((int'(ptr_q) + k) % N);
                if (!gnt_vld && req_vld[scan_idx]) begin
                    gnt_vld = 1'b1;
                    gnt_id  = scan_idx;
                end
            end
        end
        for (int k = 0; k < N; k++) begin
            if (gnt_vld && int'(gnt_id) == k) begin
                req_rdy[k] = 1'b1;
                gnt_data   = req_data[k*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        ptr_d       = ptr_q;
        pipe_data_d = pipe_data_q;
        if (gnt_vld) begin
            ptr_d       = (int'(gnt_id) == N - 1) ? '0 : gnt_id + IDW'(1);
            pipe_data_d = gnt_data;
        end
    end

    assign head_vld = tag_vld_q[LATENCY-1];
    assign head_id  = tag_id_q[LATENCY-1];

    // A result is delivered only when the pipe and the tag agree; any disagreement is sticky
    always_comb begin
        res_vld_d  = '0;
        res_data_d = res_data_q;
        err_d      = err_q;
        if (pipe_res_vld && head_vld) begin
            res_vld_d[head_id] = 1'b1;
            res_data_d         = pipe_res;
        end
        if (pipe_res_vld != head_vld) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q       <= '0;
            pipe_vld_q  <= 1'b0;
            pipe_data_q <= '0;
            pipe_id_q   <= '0;
            tag_vld_q   <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                tag_id_q[i] <= '0;
            end
            res_vld_q   <= '0;
            res_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            pipe_vld_q  <= gnt_vld;
            pipe_data_q <= pipe_data_d;
            pipe_id_q   <= gnt_id;
            tag_vld_q[0] <= pipe_vld_q;
            tag_id_q[0]  <= pipe_id_q;
            for (int i = 1; i < LATENCY; i++) begin
                tag_vld_q[i] <= tag_vld_q[i-1];
                tag_id_q[i]  <= tag_id_q[i-1];
            end
            res_vld_q   <= res_vld_d;
            res_data_q  <= res_data_d;
            err_q       <= err_d;
        end
    end

    assign pipe_vld  = pipe_vld_q;
    assign pipe_data = pipe_data_q;
    assign res_vld   = res_vld_q;
    assign res_data  = res_data_q;
    assign err       = err_q;

endmodule

// File: tb/tb_pow5_pipe_arbiter.sv
// Bench for pow5_pipe_arbiter: stub pow5 pipe, randomized and directed stimulus,
// and a queue-based reference model compared on every falling edge.
module tb_pow5_pipe_arbiter;

    localparam int N     = 4;
    localparam int W     = 8;
    localparam int LAT   = 4;
    localparam int RES_W = 5 * W;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             en  = 1'b0;
    logic [N-1:0]     req_vld  = '0;
    logic [N*W-1:0]   req_data = '0;
    logic [N-1:0]     req_rdy;
    logic             pipe_vld;
    logic [W-1:0]     pipe_data;
    logic             pipe_res_vld;
    logic [RES_W-1:0] pipe_res;
    logic [N-1:0]     res_vld;
    logic [RES_W-1:0] res_data;
    logic             err;
    logic             inject = 1'b0;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pow5_pipe_arbiter #(.N(N), .WIDTH(W), .LATENCY(LAT), .RES_W(RES_W)) dut (
        .clk(clk), .rst(rst), .en(en),
        .req_vld(req_vld), .req_data(req_data), .req_rdy(req_rdy),
        .pipe_vld(pipe_vld), .pipe_data(pipe_data),
        .pipe_res_vld(pipe_res_vld), .pipe_res(pipe_res),
        .res_vld(res_vld), .res_data(res_data), .err(err)
    );

    function automatic longint pow5(input longint x);
        return x * x * x * x * x;
    endfunction

    // Stub pow5 pipe, reset together with the arbiter; inject forces a stray result
    logic [LAT-1:0] stub_v;
    logic [W-1:0]   stub_d [LAT];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stub_v <= '0;
            for (int i = 0; i < LAT; i++) stub_d[i] <= '0;
        end else begin
            stub_v[0] <= pipe_vld;
            stub_d[0] <= pipe_data;
            for (int i = 1; i < LAT; i++) begin
                stub_v[i] <= stub_v[i-1];
                stub_d[i] <= stub_d[i-1];
            end
        end
    end
    assign pipe_res_vld = stub_v[LAT-1] | inject;
    assign pipe_res     = RES_W'(pow5(longint'(stub_d[LAT-1])));

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pointer, expected issue register, queue of results with due cycle
    typedef struct {
        int     due;
        int     id;
        longint val;
    } exp_t;

    exp_t   q[$];
    int     m_ptr = 0;
    int     m_g;
    int     cyc = 0;
    logic   m_pv = 1'b0;
    logic [W-1:0] m_pd = '0;
    longint m_rd = 0;
    logic   m_err = 1'b0;
    logic [N-1:0] exp_rdy, exp_rv;

    initial begin : compare
        forever begin
            @(negedge clk);
            if (rst) begin
                cmp("rst_req_rdy", 64'(req_rdy), 64'd0);
                cmp("rst_pipe_vld", 64'(pipe_vld), 64'd0);
                cmp("rst_res_vld", 64'(res_vld), 64'd0);
                cmp("rst_err", 64'(err), 64'd0);
                q.delete();
                m_ptr = 0; m_pv = 1'b0; m_pd = '0; m_rd = 0; m_err = 1'b0;
            end else begin
                m_g = -1;
                if (en) begin
                    for (int k = 0; k < N; k++) begin
                        if (m_g < 0 && req_vld[(m_ptr + k) % N]) m_g = (m_ptr + k) % N;
                    end
                end
                exp_rdy = (m_g >= 0) ? N'(1 << m_g) : '0;
                cmp("req_rdy", 64'(req_rdy), 64'(exp_rdy));
                cmp("pipe_vld", 64'(pipe_vld), 64'(m_pv));
                cmp("pipe_data", 64'(pipe_data), 64'(m_pd));
                exp_rv = '0;
                if (q.size() > 0 && q[0].due == cyc) begin
                    exp_rv = N'(1 << q[0].id);
                    m_rd   = q[0].val;
                    void'(q.pop_front());
                end
                cmp("res_vld", 64'(res_vld), 64'(exp_rv));
                cmp("res_data", 64'(res_data), 64'(m_rd));
                cmp("err", 64'(err), 64'(m_err));
                if (inject) m_err = 1'b1;
                if (m_g >= 0) begin
                    m_pv  = 1'b1;
                    m_pd  = req_data[m_g*W +: W];
                    m_ptr = (m_g + 1) % N;
                    q.push_back('{due: cyc + 2 + LAT, id: m_g, val: pow5(longint'(m_pd))});
                end else begin
                    m_pv = 1'b0;
                end
            end
            cyc++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic e, input logic [N-1:0] v, input logic [N*W-1:0] d);
        en = e; req_vld = v; req_data = d;
    endtask

    logic found;

    initial begin : stim
        #1 rst = 1'b1;
        tick(); tick();
        rst = 1'b0;

        // Single requester 1 with operand 3
        drive(1'b1, 4'b0010, {8'd0, 8'd0, 8'd3, 8'd0});
        #1 cmp("t1_rdy", 64'(req_rdy), 64'b0010);
        tick();
        drive(1'b1, 4'b0000, '0);
        cmp("t1_pipe_vld", 64'(pipe_vld), 64'd1);
        cmp("t1_pipe_data", 64'(pipe_data), 64'd3);
        repeat (5) tick();
        cmp("t1_res_vld", 64'(res_vld), 64'b0010);
        cmp("t1_res_data", 64'(res_data), 64'd243);
        tick();

        // Requesters 0 and 2 only; pointer sits at 2 after the grant to 1
        drive(1'b1, 4'b0101, {8'd0, 8'd7, 8'd0, 8'd5});
        #1 cmp("t3_first_rdy", 64'(req_rdy), 64'b0100);
        tick();
        #1 cmp("t3_second_rdy", 64'(req_rdy), 64'b0001);
        tick();
        drive(1'b0, 4'b0000, '0);
        repeat (LAT + 4) tick();

        // All four continuously valid, data 1,2,3,255
        drive(1'b1, 4'b1111, {8'd255, 8'd3, 8'd2, 8'd1});
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (res_vld == 4'b1000) begin
                found = 1'b1;
                cmp("t2_res_255", 64'(res_data), 64'd1078203909375);
            end
        end
        n_cmp++;
        if (!found) begin
            n_fail++;
            $display("FAIL t2_timeout: got no res_vld=1000, expected one within 20 cycles");
        end

        // en dropped for three cycles with results in flight
        drive(1'b0, 4'b1111, {8'd9, 8'd8, 8'd7, 8'd6});
        for (int i = 0; i < 3; i++) begin
            #1 cmp("t4_rdy_off", 64'(req_rdy), 64'd0);
            tick();
        end
        drive(1'b1, 4'b1111, {8'd9, 8'd8, 8'd7, 8'd6});
        repeat (LAT + 4) tick();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 7) != 0), N'($urandom), {$urandom});
            tick();
        end
        drive(1'b0, 4'b0000, '0);
        repeat (LAT + 4) tick();

        // Stray result with nothing in flight
        inject = 1'b1;
        tick();
        inject = 1'b0;
        cmp("t5_err_set", 64'(err), 64'd1);
        cmp("t5_no_res", 64'(res_vld), 64'd0);
        repeat (5) tick();
        cmp("t5_err_sticky", 64'(err), 64'd1);

        // Asynchronous reset in the middle of a stream
        drive(1'b1, 4'b1111, {$urandom});
        repeat (3) tick();
        #2 rst = 1'b1;
        #1;
        cmp("t6_pipe_vld", 64'(pipe_vld), 64'd0);
        cmp("t6_pipe_data", 64'(pipe_data), 64'd0);
        cmp("t6_res_vld", 64'(res_vld), 64'd0);
        cmp("t6_res_data", 64'(res_data), 64'd0);
        cmp("t6_err", 64'(err), 64'd0);
        cmp("t6_req_rdy", 64'(req_rdy), 64'd0);
        tick(); tick();
        rst = 1'b0;
        drive(1'b1, 4'b1010, {8'd4, 8'd0, 8'd2, 8'd0});
        #1 cmp("t6_first_rdy", 64'(req_rdy), 64'b0010);
        tick();
        drive(1'b0, 4'b0000, '0);
        repeat (LAT + 4) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
